// File: rtl/btn_pkg.sv
// btn_pkg: channel state type, default timing constants and counter-width helper for btn_conditioner.
// HELD exists only when BTN_AUTOREPEAT_EN is not defined.
package btn_pkg;

  localparam int DB_CYCLES_DEF     = 16;
  localparam int TICK_DIV_DEF      = 100000;
  localparam int REPEAT_DELAY_DEF  = 50;
  localparam int REPEAT_PERIOD_DEF = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } ch_state_e;

`ifndef BTN_AUTOREPEAT_EN
  // Without auto-repeat the channel only needs to know that the button is down.
  localparam ch_state_e HELD = DELAY;
`endif

  function automatic int rpt_cnt_w(input int delay, input int period);
    return $clog2(((delay > period) ? delay : period) + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button channel -- 2-flop synchroniser, debounce counter, press/repeat/release FSM.
// Hold-to-repeat (DELAY/REPEAT, rpt_cnt, rpt_mask) is built only with BTN_AUTOREPEAT_EN.
//
// state  | meaning
// IDLE   | debounced level low, waiting for an accepted press
// DELAY  | held, counting ticks to the first repeat (HELD when repeat is compiled out)
// REPEAT | held, one repeat every REPEAT_PERIOD ticks while rpt_mask is set
module btn_channel
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk_fast,
  input  logic rst,
  input  logic btn_raw,
  input  logic rpt_mask,
  input  logic tick,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  ch_state_e      state_q, state_d;
  logic           acc_press, acc_release;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = rpt_cnt_w(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [RW-1:0] RPT_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_PERIOD = RW'(REPEAT_PERIOD);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [RW-1:0] rpt_sat, rpt_inc;
`else
  localparam int unused_rpt_params = REPEAT_DELAY + REPEAT_PERIOD;
  logic unused_rpt_in;
  assign unused_rpt_in = rpt_mask ^ tick;
`endif

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    db_cnt_d    = '0;
    level_d     = level_q;
    acc_press   = 1'b0;
    acc_release = 1'b0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d     = sync2_q;
        acc_press   = sync2_q;
        acc_release = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rpt_cnt_d = rpt_cnt_q;
    rpt_inc   = rpt_cnt_q + 1'b1;
    // DELAY parks at its terminal count while the mask is low
    rpt_sat   = (rpt_cnt_q == RPT_DELAY) ? rpt_cnt_q : rpt_inc;
`endif
    if (acc_release) begin
      release_d = 1'b1;
      state_d   = IDLE;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_press) begin
            press_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            state_d   = DELAY;
            rpt_cnt_d = '0;
`else
            state_d   = HELD;
`endif
          end
        end
`ifdef BTN_AUTOREPEAT_EN
        DELAY: begin
          if (tick) begin
            if (rpt_sat == RPT_DELAY && rpt_mask) begin
              press_d   = 1'b1;
              rpt_cnt_d = '0;
              state_d   = REPEAT;
            end else begin
              rpt_cnt_d = rpt_sat;
            end
          end
        end
        REPEAT: begin
          if (tick) begin
            if (rpt_inc == RPT_PERIOD) begin
              press_d   = rpt_mask;
              rpt_cnt_d = '0;
            end else begin
              rpt_cnt_d = rpt_inc;
            end
          end
        end
`else
        HELD: state_d = HELD;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      state_q   <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_q <= '0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      state_q   <= state_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_q <= rpt_cnt_d;
`endif
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_CH-channel push-button front end; owns the shared repeat prescaler and channel fan-out.
// Hold-to-repeat is compiled in when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_CH          = 5,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int TICK_DIV      = TICK_DIV_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic            clk_fast,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  input  logic [N_CH-1:0] rpt_mask,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release
);

  logic tick;

`ifdef BTN_AUTOREPEAT_EN
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end
`else
  localparam int unused_tick_div = TICK_DIV;
  assign tick = 1'b0;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk_fast   (clk_fast),
      .rst        (rst),
      .btn_raw    (btn_raw[i]),
      .rpt_mask   (rpt_mask[i]),
      .tick       (tick),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed stimulus with a per-cycle behavioural model plus hand-computed
// edge expectations for btn_conditioner (N_CH=5, DB_CYCLES=4, TICK_DIV=10, REPEAT_DELAY=3, REPEAT_PERIOD=2).
module tb_btn_conditioner;

  localparam int N  = 5;
  localparam int DB = 4;
  localparam int TD = 10;
  localparam int RD = 3;
  localparam int RP = 2;

  logic         clk_fast = 1'b0;
  logic         rst      = 1'b1;
  logic [N-1:0] btn_raw  = '0;
  logic [N-1:0] rpt_mask = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;

  int vectors     = 0;
  int miscompares = 0;
  int ecnt        = 0;
  int press_cnt[N];
  int rel_cnt[N];
  int p3_edges[$];

  // Model state: two-stage delay line, window of the last DB delayed samples, accepted level.
  bit m_s1[N], m_s2[N], m_lvl[N];
  bit m_win[N][DB];
`ifdef BTN_AUTOREPEAT_EN
  int m_tc[N];
  bit m_inrpt[N];
  int m_last_fire[N];
`endif
  logic [N-1:0] e_lvl = '0, e_press = '0, e_rel = '0;

  btn_conditioner #(
    .N_CH         (N),
    .DB_CYCLES    (DB),
    .TICK_DIV     (TD),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk_fast   (clk_fast),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .rpt_mask   (rpt_mask),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, ecnt, act, exp);
    end
  endtask

  // Returns on the falling edge that follows rising edge e (counted from reset release).
  task automatic at_edge(input int e);
    int guard = 0;
    while (ecnt < e && guard < 5000) begin
      @(negedge clk_fast);
      guard++;
    end
    if (ecnt < e) begin
      vectors++;
      miscompares++;
      $display("FAIL at_edge timeout: edge %0d, waiting for %0d", ecnt, e);
    end
  endtask

  initial begin : scoreboard
    logic [N-1:0] raw_s;
    bit d, all_diff;
`ifdef BTN_AUTOREPEAT_EN
    logic [N-1:0] mask_s;
    bit tick;
`endif
    forever begin
      @(posedge clk_fast);
      raw_s = btn_raw;
`ifdef BTN_AUTOREPEAT_EN
      mask_s = rpt_mask;
`endif
      if (rst) begin
        ecnt = 0;
        for (int c = 0; c < N; c++) begin
          m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0;
          for (int k = 0; k < DB; k++) m_win[c][k] = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
          m_tc[c] = 0; m_inrpt[c] = 1'b0;
`endif
        end
        e_lvl = '0; e_press = '0; e_rel = '0;
      end else begin
        ecnt++;
`ifdef BTN_AUTOREPEAT_EN
        tick = (ecnt % TD) == 0;
`endif
        e_press = '0;
        e_rel   = '0;
        for (int c = 0; c < N; c++) begin
          d       = m_s2[c];
          m_s2[c] = m_s1[c];
          m_s1[c] = raw_s[c];
          for (int k = DB - 1; k > 0; k--) m_win[c][k] = m_win[c][k-1];
          m_win[c][0] = d;
          all_diff = 1'b1;
          for (int k = 0; k < DB; k++) if (m_win[c][k] == m_lvl[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_lvl[c] = ~m_lvl[c];
            if (m_lvl[c]) begin
              e_press[c] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              m_tc[c] = 0; m_inrpt[c] = 1'b0;
`endif
            end else begin
              e_rel[c] = 1'b1;
            end
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (m_lvl[c] && tick) begin
            m_tc[c]++;
            if (!m_inrpt[c]) begin
              if (m_tc[c] >= RD && mask_s[c]) begin
                e_press[c] = 1'b1; m_tc[c] = 0; m_inrpt[c] = 1'b1; m_last_fire[c] = ecnt;
              end
            end else if (m_tc[c] == RP) begin
              m_tc[c] = 0;
              if (mask_s[c]) begin
                e_press[c] = 1'b1; m_last_fire[c] = ecnt;
              end
            end
          end
`endif
          e_lvl[c] = m_lvl[c];
        end
      end
      #1;
      check("btn_level", 32'(btn_level), 32'(e_lvl));
      check("btn_press", 32'(btn_press), 32'(e_press));
      check("btn_release", 32'(btn_release), 32'(e_rel));
      for (int c = 0; c < N; c++) begin
        if (btn_press[c]) press_cnt[c]++;
        if (btn_release[c]) rel_cnt[c]++;
      end
      if (btn_press[3]) p3_edges.push_back(ecnt);
    end
  end

  initial begin : stimulus
    int t, p_before, r_before, gap;
    repeat (3) @(negedge clk_fast);
    rst = 1'b0;

    // Async reset while all buttons are held, then re-acceptance.
    at_edge(5);  btn_raw = 5'h1F;
    at_edge(14); check("pre_reset_level", 32'(btn_level), 32'h1F);
    @(posedge clk_fast);
    #3 rst = 1'b1;
    #1;
    check("async_rst_level", 32'(btn_level), 0);
    check("async_rst_press", 32'(btn_press), 0);
    check("async_rst_release", 32'(btn_release), 0);
    @(posedge clk_fast);
    @(negedge clk_fast);
    rst = 1'b0;
    at_edge(5);  check("rearm_level_e5", 32'(btn_level), 0);
    at_edge(6);  check("rearm_level_e6", 32'(btn_level), 32'h1F);
                 check("rearm_press_e6", 32'(btn_press), 32'h1F);
    at_edge(7);  check("rearm_press_e7", 32'(btn_press), 0);
    at_edge(10); btn_raw = '0;
    at_edge(16); check("release_all_e16", 32'(btn_release), 32'h1F);

    // Glitches of 1, 2 and 3 cycles on channel 0, then a 4-cycle pulse.
    p_before = press_cnt[0];
    at_edge(20); btn_raw[0] = 1'b1;
    at_edge(21); btn_raw[0] = 1'b0;
    at_edge(30); btn_raw[0] = 1'b1;
    at_edge(32); btn_raw[0] = 1'b0;
    at_edge(40); btn_raw[0] = 1'b1;
    at_edge(43); btn_raw[0] = 1'b0;
    at_edge(55); check("glitch_no_press", press_cnt[0] - p_before, 0);
                 check("glitch_level", 32'(btn_level[0]), 0);
    at_edge(60); btn_raw[0] = 1'b1;
    at_edge(64); btn_raw[0] = 1'b0;
    at_edge(66); check("pulse4_press", 32'(btn_press[0]), 1);
                 check("pulse4_level", 32'(btn_level[0]), 1);
    at_edge(69); check("pulse4_rel_early", 32'(btn_release[0]), 0);
    at_edge(70); check("pulse4_release", 32'(btn_release[0]), 1);

`ifdef BTN_AUTOREPEAT_EN
    // Hold channel 3 with repeat enabled; release exactly when a repeat is due.
    at_edge(80); p3_edges.delete(); rpt_mask[3] = 1'b1; btn_raw[3] = 1'b1;
    at_edge(275);
    t = m_last_fire[3] + RP * TD;
    check("rpt_release_target", t, 290);
    at_edge(t - 6); btn_raw[3] = 1'b0;
    at_edge(t);
    check("rel_over_repeat_press", 32'(btn_press[3]), 0);
    check("rel_over_repeat_rel", 32'(btn_release[3]), 1);
    check("rpt_strobe_count", 32'(p3_edges.size() >= 9), 1);
    if (p3_edges.size() >= 2) begin
      check("ch3_press_edge", p3_edges[0], 86);
      gap = p3_edges[1] - p3_edges[0];
      check("first_repeat_gap", 32'(gap >= 20 && gap <= 30), 1);
      for (int i = 2; i < p3_edges.size(); i++)
        check("repeat_gap", p3_edges[i] - p3_edges[i-1], RP * TD);
    end
    p_before = press_cnt[3];
    r_before = rel_cnt[3];
    at_edge(t + 50);
    check("after_release_press", press_cnt[3] - p_before, 0);
    check("after_release_rel", rel_cnt[3] - r_before, 0);
    rpt_mask[3] = 1'b0;

    // Channel 1 held with the mask low, raised later, then gated again in REPEAT.
    at_edge(350); p_before = press_cnt[1]; btn_raw[1] = 1'b1;
    at_edge(456); check("masked_single_press", press_cnt[1] - p_before, 1);
                  rpt_mask[1] = 1'b1;
    at_edge(459); check("mask_raise_early", 32'(btn_press[1]), 0);
    at_edge(460); check("mask_raise_fire", 32'(btn_press[1]), 1);
    at_edge(470); rpt_mask[1] = 1'b0;
    at_edge(480); check("repeat_suppressed", 32'(btn_press[1]), 0);
    at_edge(515); rpt_mask[1] = 1'b1;
    at_edge(520); check("repeat_resumed", 32'(btn_press[1]), 1);
    at_edge(540); btn_raw[1] = 1'b0;
    at_edge(546); check("ch1_release", 32'(btn_release[1]), 1);
                  rpt_mask[1] = 1'b0;
`endif

    // Simultaneous press on channels 0, 2, 4.
    at_edge(560); rpt_mask = 5'b10101; btn_raw = 5'b10101;
    at_edge(566); check("simul_press", 32'(btn_press), 32'h15);
                  check("simul_level", 32'(btn_level), 32'h15);
`ifdef BTN_AUTOREPEAT_EN
    at_edge(612); t = m_last_fire[0] + RP * TD;
`else
    t = 630;
`endif
    at_edge(t - 6); btn_raw = '0;
    at_edge(t);   check("simul_release", 32'(btn_release), 32'h15);
                  check("simul_rel_press", 32'(btn_press), 0);
    rpt_mask = '0;

`ifndef BTN_AUTOREPEAT_EN
    // Long hold without repeat: one press and one release only.
    at_edge(700); p_before = press_cnt[2]; r_before = rel_cnt[2]; btn_raw[2] = 1'b1;
    at_edge(1200); btn_raw[2] = 1'b0;
    at_edge(1220);
    check("noauto_press_count", press_cnt[2] - p_before, 1);
    check("noauto_release_count", rel_cnt[2] - r_before, 1);
`endif

    at_edge(ecnt + 30);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #100000;
    miscompares++;
    $display("FAIL watchdog: time limit reached at edge %0d", ecnt);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "time limit");
  end

endmodule
